// File: rtl/a23_copro15_pkg.sv
// Shared definitions for the CP15 system-control block: register numbers,
// coprocessor operation codes and the cache-flush handshake states.
package a23_copro15_pkg;

    localparam logic [3:0] CRN_ID         = 4'd0;
    localparam logic [3:0] CRN_FLUSH      = 4'd1;
    localparam logic [3:0] CRN_CTRL       = 4'd2;
    localparam logic [3:0] CRN_CACHEABLE  = 4'd3;
    localparam logic [3:0] CRN_UPDATEABLE = 4'd4;
    localparam logic [3:0] CRN_DISRUPTIVE = 4'd5;
    localparam logic [3:0] CRN_FSTATUS    = 4'd6;
    localparam logic [3:0] CRN_FADDR      = 4'd7;
    localparam logic [3:0] CRN_FPOP       = 4'd8;
    localparam logic [3:0] CRN_FLUSHSTAT  = 4'd9;

    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;

    typedef enum logic [1:0] {
        FLUSH_IDLE = 2'd0,
        FLUSH_REQ  = 2'd1,
        FLUSH_GAP  = 2'd2
    } flush_state_t;

endpackage

// File: rtl/a23_fault_fifo.sv
// Fault log FIFO: circular buffer with push/pop/clear, sticky overflow on
// dropped pushes. Clear takes effect before a same-cycle push.
module a23_fault_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 40,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             overflow
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_pop;
    logic             do_push;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty && !clear;
    // A pop in the same cycle frees the slot the push lands in.
    assign do_push = push && (!full || do_pop);
    assign wr_en   = clear ? push : do_push;
    assign wr_addr = clear ? '0 : wr_ptr;

    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            rd_ptr   <= '0;
            wr_ptr   <= push ? AW'(1) : '0;
            count    <= push ? CW'(1) : '0;
            overflow <= 1'b0;
        end else begin
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
            if (push && !do_push) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/a23_copro15_ctrl.sv
// CP15 system-control block: cache control, region masks, fault log and a
// request/acknowledge cache flush with single-entry coalescing.
module a23_copro15_ctrl
    import a23_copro15_pkg::*;
#(
    parameter int          REGION_BITS = 32,
    parameter int          FAULT_DEPTH = 4,
    parameter logic [31:0] CPU_ID      = 32'h4156_0400
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_fetch_stall,
    input  logic [3:0]             i_copro_crn,
    input  logic [1:0]             i_copro_operation,
    input  logic [31:0]            i_copro_write_data,
    input  logic                   i_fault,
    input  logic [7:0]             i_fault_status,
    input  logic [31:0]            i_fault_address,
    input  logic                   i_cache_flush_ack,
    output logic [31:0]            o_copro_read_data,
    output logic                   o_cache_enable,
    output logic                   o_cache_flush_req,
    output logic [REGION_BITS-1:0] o_cacheable_area,
    output logic [REGION_BITS-1:0] o_updateable_area,
    output logic [REGION_BITS-1:0] o_disruptive_area,
    output logic                   o_fault_pending
);

    localparam int CW = $clog2(FAULT_DEPTH) + 1;

    logic [2:0]   cache_control;
    flush_state_t flush_state;
    logic         flush_pending;
    logic         flush_busy;
    logic         wr_en;
    logic         flush_wr;
    logic         fifo_pop;
    logic         fifo_clear;
    logic         fifo_push;
    logic [39:0]  head_data;
    logic [CW-1:0] fifo_count;
    logic         fifo_full;
    logic         fifo_empty;
    logic         fifo_overflow;
    logic [7:0]   head_status;
    logic [31:0]  head_address;
    logic [31:0]  read_next;

    function automatic logic [31:0] zext(input logic [REGION_BITS-1:0] mask);
        zext = '0;
        zext[REGION_BITS-1:0] = mask;
    endfunction

    assign wr_en      = !i_fetch_stall && (i_copro_operation == OP_WRITE);
    assign flush_wr   = wr_en && (i_copro_crn == CRN_FLUSH);
    assign fifo_pop   = wr_en && (i_copro_crn == CRN_FPOP) && !i_copro_write_data[0];
    assign fifo_clear = wr_en && (i_copro_crn == CRN_FPOP) && i_copro_write_data[0];
    assign fifo_push  = !i_fetch_stall && i_fault;
    assign flush_busy = (flush_state != FLUSH_IDLE);

    assign head_status  = fifo_empty ? 8'd0  : head_data[39:32];
    assign head_address = fifo_empty ? 32'd0 : head_data[31:0];

    assign o_cache_enable  = cache_control[0];
    assign o_fault_pending = !fifo_empty;

    a23_fault_fifo #(
        .DEPTH (FAULT_DEPTH),
        .WIDTH (40)
    ) u_fault_fifo (
        .clk       (i_clk),
        .rst       (i_rst),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .clear     (fifo_clear),
        .push_data ({i_fault_status, i_fault_address}),
        .head_data (head_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .overflow  (fifo_overflow)
    );

    always_comb begin
        read_next = 32'd0;
        case (i_copro_crn)
            CRN_ID:         read_next = CPU_ID;
            CRN_CTRL:       read_next = {29'd0, cache_control};
            CRN_CACHEABLE:  read_next = zext(o_cacheable_area);
            CRN_UPDATEABLE: read_next = zext(o_updateable_area);
            CRN_DISRUPTIVE: read_next = zext(o_disruptive_area);
            CRN_FSTATUS:    read_next = {fifo_overflow, 15'd0, 8'(fifo_count), head_status};
            CRN_FADDR:      read_next = head_address;
            CRN_FLUSHSTAT:  read_next = {30'd0, flush_pending, flush_busy};
            default:        read_next = 32'd0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cache_control     <= '0;
            o_cacheable_area  <= '0;
            o_updateable_area <= '0;
            o_disruptive_area <= '0;
            o_copro_read_data <= '0;
        end else if (!i_fetch_stall) begin
            o_copro_read_data <= read_next;
            if (wr_en) begin
                case (i_copro_crn)
                    CRN_CTRL:       cache_control     <= i_copro_write_data[2:0];
                    CRN_CACHEABLE:  o_cacheable_area  <= i_copro_write_data[REGION_BITS-1:0];
                    CRN_UPDATEABLE: o_updateable_area <= i_copro_write_data[REGION_BITS-1:0];
                    CRN_DISRUPTIVE: o_disruptive_area <= i_copro_write_data[REGION_BITS-1:0];
                    default: ;
                endcase
            end
        end
    end

    // The ack comes from the cache, so it is honoured even while the core stalls.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            flush_state       <= FLUSH_IDLE;
            flush_pending     <= 1'b0;
            o_cache_flush_req <= 1'b0;
        end else begin
            case (flush_state)
                FLUSH_IDLE: begin
                    if (flush_wr) begin
                        flush_state       <= FLUSH_REQ;
                        o_cache_flush_req <= 1'b1;
                    end
                end
                FLUSH_REQ: begin
                    if (i_cache_flush_ack) begin
                        o_cache_flush_req <= 1'b0;
                        flush_pending     <= 1'b0;
                        flush_state       <= (flush_pending || flush_wr) ? FLUSH_GAP : FLUSH_IDLE;
                    end else if (flush_wr) begin
                        flush_pending <= 1'b1;
                    end
                end
                FLUSH_GAP: begin
                    flush_state       <= FLUSH_REQ;
                    o_cache_flush_req <= 1'b1;
                    if (flush_wr) begin
                        flush_pending <= 1'b1;
                    end
                end
                default: begin
                    flush_state       <= FLUSH_IDLE;
                    flush_pending     <= 1'b0;
                    o_cache_flush_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_a23_copro15_ctrl.sv
// Self-checking bench for a23_copro15_ctrl: directed scenarios plus a
// randomized run against a queue-based behavioural model.
module tb_a23_copro15_ctrl;

    localparam int          RB     = 8;
    localparam int          FD     = 4;
    localparam logic [31:0] CPU_ID = 32'h4156_0400;

    logic          clk;
    logic          rst;
    logic          fetch_stall;
    logic [3:0]    copro_crn;
    logic [1:0]    copro_operation;
    logic [31:0]   copro_write_data;
    logic          fault;
    logic [7:0]    fault_status;
    logic [31:0]   fault_address;
    logic          cache_flush_ack;
    logic [31:0]   copro_read_data;
    logic          cache_enable;
    logic          cache_flush_req;
    logic [RB-1:0] cacheable_area;
    logic [RB-1:0] updateable_area;
    logic [RB-1:0] disruptive_area;
    logic          fault_pending;

    int tests = 0;
    int fails = 0;

    // Behavioural model state
    logic [39:0]   m_q[$];
    logic          m_ovf;
    logic [2:0]    m_ctrl;
    logic [RB-1:0] m_cache, m_upd, m_dis;
    logic [31:0]   m_rd;
    logic          m_req, m_gap, m_pend;

    a23_copro15_ctrl #(
        .REGION_BITS (RB),
        .FAULT_DEPTH (FD),
        .CPU_ID      (CPU_ID)
    ) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_fetch_stall      (fetch_stall),
        .i_copro_crn        (copro_crn),
        .i_copro_operation  (copro_operation),
        .i_copro_write_data (copro_write_data),
        .i_fault            (fault),
        .i_fault_status     (fault_status),
        .i_fault_address    (fault_address),
        .i_cache_flush_ack  (cache_flush_ack),
        .o_copro_read_data  (copro_read_data),
        .o_cache_enable     (cache_enable),
        .o_cache_flush_req  (cache_flush_req),
        .o_cacheable_area   (cacheable_area),
        .o_updateable_area  (updateable_area),
        .o_disruptive_area  (disruptive_area),
        .o_fault_pending    (fault_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_q.delete();
        m_ovf = 0; m_ctrl = 0; m_cache = 0; m_upd = 0; m_dis = 0;
        m_rd = 0; m_req = 0; m_gap = 0; m_pend = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [3:0] crn);
        logic [7:0]  st;
        logic [31:0] ad;
        st = (m_q.size() != 0) ? m_q[0][39:32] : 8'd0;
        ad = (m_q.size() != 0) ? m_q[0][31:0]  : 32'd0;
        case (crn)
            4'd0:    return CPU_ID;
            4'd2:    return {29'd0, m_ctrl};
            4'd3:    return {24'd0, m_cache};
            4'd4:    return {24'd0, m_upd};
            4'd5:    return {24'd0, m_dis};
            4'd6:    return {m_ovf, 15'd0, 8'(m_q.size()), st};
            4'd7:    return ad;
            4'd9:    return {30'd0, m_pend, m_req || m_gap};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step();
        logic wr, wr1;
        wr  = !fetch_stall && copro_operation == 2'd2;
        wr1 = wr && copro_crn == 4'd1;
        if (!fetch_stall) m_rd = model_read(copro_crn);
        // Flush handshake: one outstanding request plus at most one queued.
        if (m_gap) begin
            m_gap = 0; m_req = 1;
            if (wr1) m_pend = 1;
        end else if (m_req) begin
            if (cache_flush_ack) begin
                m_req = 0;
                if (m_pend || wr1) begin m_pend = 0; m_gap = 1; end
            end else if (wr1) m_pend = 1;
        end else if (wr1) m_req = 1;
        if (wr) begin
            case (copro_crn)
                4'd2: m_ctrl  = copro_write_data[2:0];
                4'd3: m_cache = copro_write_data[RB-1:0];
                4'd4: m_upd   = copro_write_data[RB-1:0];
                4'd5: m_dis   = copro_write_data[RB-1:0];
                4'd8: begin
                    if (copro_write_data[0]) begin m_q.delete(); m_ovf = 0; end
                    else if (m_q.size() != 0) void'(m_q.pop_front());
                end
                default: ;
            endcase
        end
        if (!fetch_stall && fault) begin
            if (m_q.size() < FD) m_q.push_back({fault_status, fault_address});
            else m_ovf = 1;
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [3:0] crn, input logic [31:0] data,
                         input logic f, input logic [7:0] fs, input logic [31:0] fa,
                         input logic ack, input logic stall);
        copro_operation = op; copro_crn = crn; copro_write_data = data;
        fault = f; fault_status = fs; fault_address = fa;
        cache_flush_ack = ack; fetch_stall = stall;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1;
        model_reset();
        #1;
        tests++;
        if ({copro_read_data, cache_enable, cache_flush_req, fault_pending} !== 35'd0) begin
            fails++;
            $display("FAIL reset_outputs: rd=%h en=%b req=%b pend=%b, required all 0",
                     copro_read_data, cache_enable, cache_flush_req, fault_pending);
        end
        tests++;
        if ({cacheable_area, updateable_area, disruptive_area} !== 24'd0) begin
            fails++;
            $display("FAIL reset_masks: %h %h %h, required 0", cacheable_area, updateable_area, disruptive_area);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        tests++;
        if (copro_read_data !== CPU_ID) begin
            fails++;
            $display("FAIL read_id: got %h, required %h", copro_read_data, CPU_ID);
        end
    endtask

    task automatic test_ctrl_masks();
        drive(2, 2, 32'h0000_0005, 0, 0, 0, 0, 0); cycle();
        drive(2, 3, 32'hFFFF_FFA5, 0, 0, 0, 0, 0); cycle();
        drive(0, 3, 0, 0, 0, 0, 0, 0);             cycle();
        tests++;
        if (cache_enable !== 1'b1) begin
            fails++; $display("FAIL cache_enable: got %b, required 1", cache_enable);
        end
        tests++;
        if (cacheable_area !== 8'hA5) begin
            fails++; $display("FAIL cacheable_area: got %h, required a5", cacheable_area);
        end
        tests++;
        if (copro_read_data !== 32'h0000_00A5) begin
            fails++; $display("FAIL read_crn3: got %h, required 000000a5", copro_read_data);
        end
    endtask

    task automatic test_fault_overflow();
        for (int i = 1; i <= 5; i++) begin
            drive(0, 6, 0, 1, 8'(17 * i), 32'(256 * i), 0, 0); cycle();
        end
        drive(0, 6, 0, 0, 0, 0, 0, 0); cycle();
        tests++;
        if (copro_read_data !== 32'h8000_0411) begin
            fails++; $display("FAIL overflow_status: got %h, required 80000411", copro_read_data);
        end
        drive(0, 7, 0, 0, 0, 0, 0, 0); cycle();
        tests++;
        if (copro_read_data !== 32'h0000_0100) begin
            fails++; $display("FAIL head_addr: got %h, required 00000100", copro_read_data);
        end
        drive(2, 8, 0, 0, 0, 0, 0, 0); cycle();
        drive(0, 7, 0, 0, 0, 0, 0, 0); cycle();
        tests++;
        if (copro_read_data !== 32'h0000_0200) begin
            fails++; $display("FAIL pop_head_addr: got %h, required 00000200", copro_read_data);
        end
        drive(0, 6, 0, 0, 0, 0, 0, 0); cycle();
        tests++;
        if (copro_read_data !== 32'h8000_0322) begin
            fails++; $display("FAIL pop_status: got %h, required 80000322", copro_read_data);
        end
    endtask

    task automatic test_full_push_pop();
        drive(2, 8, 1, 0, 0, 0, 0, 0); cycle();
        for (int i = 0; i < 4; i++) begin
            drive(0, 6, 0, 1, 8'(i + 1), 32'h1000 + 32'(i), 0, 0); cycle();
        end
        drive(2, 8, 0, 1, 8'h77, 32'h0000_0AAA, 0, 0); cycle();
        drive(0, 6, 0, 0, 0, 0, 0, 0); cycle();
        tests++;
        if (copro_read_data !== 32'h0000_0402) begin
            fails++; $display("FAIL full_push_pop: got %h, required 00000402", copro_read_data);
        end
        for (int i = 0; i < 3; i++) begin
            drive(2, 8, 0, 0, 0, 0, 0, 0); cycle();
        end
        drive(0, 7, 0, 0, 0, 0, 0, 0); cycle();
        tests++;
        if (copro_read_data !== 32'h0000_0AAA) begin
            fails++; $display("FAIL tail_entry_addr: got %h, required 00000aaa", copro_read_data);
        end
        drive(2, 8, 1, 1, 8'h99, 32'h0000_BEEF, 0, 0); cycle();
        drive(0, 6, 0, 0, 0, 0, 0, 0); cycle();
        tests++;
        if (copro_read_data !== 32'h0000_0199) begin
            fails++; $display("FAIL clear_and_push: got %h, required 00000199", copro_read_data);
        end
    endtask

    task automatic test_flush_coalesce();
        logic [31:0] exp_rd [8] = '{32'd0, 32'd0, 32'd3, 32'd3, 32'd1, 32'd1, 32'd0, 32'd0};
        logic        exp_rq [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int c = 0; c < 8; c++) begin
            case (c)
                0, 1:    drive(2, 1, 0, 0, 0, 0, 0, 0);
                3, 5, 6: drive(0, 9, 0, 0, 0, 0, 1, 0);
                default: drive(0, 9, 0, 0, 0, 0, 0, 0);
            endcase
            cycle();
            tests++;
            if (cache_flush_req !== exp_rq[c] || copro_read_data !== exp_rd[c]) begin
                fails++;
                $display("FAIL flush_seq[%0d]: req=%b rd=%h, required req=%b rd=%h",
                         c, cache_flush_req, copro_read_data, exp_rq[c], exp_rd[c]);
            end
        end
    endtask

    task automatic test_stall();
        drive(2, 8, 1, 0, 0, 0, 0, 0); cycle();
        drive(0, 2, 0, 0, 0, 0, 0, 0); cycle();
        drive(2, 2, 0, 1, 8'h12, 32'h34, 0, 1); cycle();
        drive(0, 0, 0, 1, 8'h12, 32'h34, 0, 1); cycle();
        tests++;
        if (copro_read_data !== 32'd5 || cache_enable !== 1'b1 || fault_pending !== 1'b0) begin
            fails++;
            $display("FAIL stall_hold: rd=%h en=%b fp=%b, required rd=00000005 en=1 fp=0",
                     copro_read_data, cache_enable, fault_pending);
        end
        drive(0, 6, 0, 0, 0, 0, 0, 0); cycle();
        tests++;
        if (copro_read_data !== 32'd0) begin
            fails++; $display("FAIL stall_no_push: got %h, required 00000000", copro_read_data);
        end
    endtask

    task automatic test_reset_mid_flush();
        drive(2, 1, 0, 0, 0, 0, 0, 0); cycle();
        tests++;
        if (cache_flush_req !== 1'b1) begin
            fails++; $display("FAIL flush_req_set: got %b, required 1", cache_flush_req);
        end
        drive(0, 9, 0, 0, 0, 0, 0, 0);
        rst = 1;
        model_reset();
        #1;
        tests++;
        if (cache_flush_req !== 1'b0) begin
            fails++; $display("FAIL async_reset_req: got %b, required 0", cache_flush_req);
        end
        @(negedge clk);
        rst = 0;
        cycle();
        tests++;
        if (copro_read_data !== 32'd0 || cache_flush_req !== 1'b0) begin
            fails++;
            $display("FAIL reset_flushstat: rd=%h req=%b, required 0 0", copro_read_data, cache_flush_req);
        end
    endtask

    task automatic test_random();
        logic [3:0]  crn;
        logic [31:0] data;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            crn  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            data = $urandom;
            if (crn == 4'd8) data[0] = ($urandom_range(0, 4) == 0);
            drive(2'($urandom_range(0, 3)), crn, data, $urandom_range(0, 2) == 0,
                  8'($urandom), $urandom, $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0);
            cycle();
            tests++;
            if (copro_read_data !== m_rd || cache_flush_req !== m_req ||
                fault_pending !== (m_q.size() != 0) || cache_enable !== m_ctrl[0] ||
                cacheable_area !== m_cache || updateable_area !== m_upd || disruptive_area !== m_dis) begin
                fails++;
                $display("FAIL random[%0d]: rd=%h req=%b fp=%b en=%b m=%h/%h/%h, required rd=%h req=%b fp=%b en=%b m=%h/%h/%h",
                         n, copro_read_data, cache_flush_req, fault_pending, cache_enable,
                         cacheable_area, updateable_area, disruptive_area,
                         m_rd, m_req, m_q.size() != 0, m_ctrl[0], m_cache, m_upd, m_dis);
            end
        end
    endtask

    initial begin
        rst = 0;
        model_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_ctrl_masks();
        test_fault_overflow();
        test_full_push_pop();
        test_flush_coalesce();
        test_stall();
        test_reset_mid_flush();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
